// File: rtl/rx_frame_filter.sv
// Store-and-forward Ethernet RX filter: buffers each frame, forwards only clean frames to FPGA_MAC_ADDR.
// Optional define RX_FILTER_BROADCAST_EN additionally accepts destination ff:ff:ff:ff:ff:ff.
`timescale 1ns/1ps
module rx_frame_filter #(
    parameter logic [47:0] FPGA_MAC_ADDR   = 48'h5a0102030405,
    parameter int          ADDR_WIDTH      = 9,
    parameter int          MIN_FRAME_BYTES = 14,
    parameter int          MAX_FRAME_BYTES = 256
) (
    input  logic        gtx_tclk_i,
    input  logic        gtx_tresetn_i,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        drop_pulse,
    output logic [1:0]  dbg_wr_state_o
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int LEN_W = ADDR_WIDTH + 2;
    localparam logic [PTR_W-1:0] DEPTH   = PTR_W'(1) << ADDR_WIDTH;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);
`ifdef RX_FILTER_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {SYNC, HDR, BODY, DROP} wr_state_e;

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d, len_nx;
    logic             uc_ok_q, uc_ok_d, bc_ok_q, bc_ok_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic             ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
    logic [8:0]       out_data_q, out_data_d;

    logic [8:0]       mem [2**ADDR_WIDTH];
    logic [8:0]       ram_q;
    logic             mem_we, rd_en, out_ld, full, commit, drop, hdr_uc, hdr_bc;
    logic [8:0]       mem_wdata;
    logic [7:0]       mac_byte;

    // Destination MAC is compared most significant byte first.
    always_comb begin
        case (len_q[2:0])
            3'd0:    mac_byte = FPGA_MAC_ADDR[47:40];
            3'd1:    mac_byte = FPGA_MAC_ADDR[39:32];
            3'd2:    mac_byte = FPGA_MAC_ADDR[31:24];
            3'd3:    mac_byte = FPGA_MAC_ADDR[23:16];
            3'd4:    mac_byte = FPGA_MAC_ADDR[15:8];
            default: mac_byte = FPGA_MAC_ADDR[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        uc_ok_d      = uc_ok_q;
        bc_ok_d      = bc_ok_q;
        mem_we       = 1'b0;
        mem_wdata    = {s_axis_tlast, s_axis_tdata};
        commit       = 1'b0;
        drop         = 1'b0;
        len_nx       = len_q + 1'b1;
        hdr_uc       = uc_ok_q && (s_axis_tdata == mac_byte);
        hdr_bc       = BCAST_EN && bc_ok_q && (s_axis_tdata == 8'hff);
        full         = (wr_ptr_q - rd_ptr_q) == DEPTH;
        if (s_axis_tvalid) begin
            case (state_q)
                SYNC: if (s_axis_tlast) state_d = HDR;
                HDR, BODY: begin
                    if (full || (state_q == HDR && !(hdr_uc || hdr_bc)) ||
                        (state_q == BODY && len_nx > MAX_LEN)) begin
                        if (s_axis_tlast) drop = 1'b1;
                        else              state_d = DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_nx;
                        if (state_q == HDR) begin
                            uc_ok_d = hdr_uc;
                            bc_ok_d = hdr_bc;
                            if (len_q == LEN_W'(5)) state_d = BODY;
                        end
                        if (s_axis_tlast) begin
                            if (!s_axis_tuser && (state_q == BODY || len_q == LEN_W'(5)) &&
                                len_nx >= MIN_LEN)
                                commit = 1'b1;
                            else
                                drop = 1'b1;
                        end
                    end
                end
                default: if (s_axis_tlast) drop = 1'b1;
            endcase
        end
        if (commit) commit_ptr_d = wr_ptr_q + 1'b1;
        if (drop)   wr_ptr_d     = commit_ptr_q;
        if (commit || drop) begin
            state_d = HDR;
            len_d   = '0;
            uc_ok_d = 1'b1;
            bc_ok_d = 1'b1;
        end
    end

    assign frame_cnt_d  = frame_cnt_q + 16'(commit);
    assign drop_cnt_d   = (drop && drop_cnt_q != 16'hffff) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    assign drop_pulse_d = drop;

    // Output handshake: m_axis_tvalid stays high with tdata/tlast frozen until a cycle
    // where m_axis_tready is also high; that cycle is the transfer.
    always_comb begin
        out_ld     = !out_vld_q || m_axis_tready;
        rd_en      = (!ram_vld_q || out_ld) && (rd_ptr_q != commit_ptr_q);
        rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
        ram_vld_d  = rd_en ? 1'b1 : (out_ld ? 1'b0 : ram_vld_q);
        out_vld_d  = out_ld ? ram_vld_q : out_vld_q;
        out_data_d = (out_ld && ram_vld_q) ? ram_q : out_data_q;
    end

    always_ff @(posedge gtx_tclk_i) begin
        if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= mem_wdata;
        if (rd_en)  ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
        if (gtx_tresetn_i) begin
            state_q      <= SYNC;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            uc_ok_q      <= 1'b1;
            bc_ok_q      <= 1'b1;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            uc_ok_q      <= uc_ok_d;
            bc_ok_q      <= bc_ok_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            ram_vld_q    <= ram_vld_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
        end
    end

    assign m_axis_tdata   = out_data_q[7:0];
    assign m_axis_tlast   = out_data_q[8];
    assign m_axis_tvalid  = out_vld_q;
    assign frame_count    = frame_cnt_q;
    assign drop_count     = drop_cnt_q;
    assign drop_pulse     = drop_pulse_q;
    assign dbg_wr_state_o = state_q;
endmodule

// File: tb/tb_rx_frame_filter.sv
// Bench for rx_frame_filter: directed steps plus random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_frame_filter;
    localparam logic [47:0] MAC     = 48'h5a0102030405;
    localparam int          DEPTH   = 512;
    localparam int          MIN_LEN = 14;
    localparam int          MAX_LEN = 256;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b0;
    logic [15:0] frame_count, drop_count;
    logic        drop_pulse;
    logic [1:0]  dbg_state;

    logic [8:0]  exp_q[$];
    int          checks = 0, passes = 0, fails = 0;
    int          exp_frames = 0, exp_drops = 0, exp_pulses = 0, pulse_cnt = 0;
    bit          cap_track = 1'b0;
    int          held = 0;
    int          rdy_mode = 1;

    always #4 clk = ~clk;

    rx_frame_filter dut (
        .gtx_tclk_i    (clk),
        .gtx_tresetn_i (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .drop_pulse    (drop_pulse),
        .dbg_wr_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bytes_t make_frame(input logic [47:0] dest, input int len);
        bytes_t f;
        for (int i = 0; i < len; i++) begin
            if (i < 6) f.push_back(dest[8*(5-i) +: 8]);
            else       f.push_back(8'($urandom_range(0, 255)));
        end
        return f;
    endfunction

    // Frame-level acceptance rule: clean, length in range, addressed to us.
    function automatic bit frame_ok(input bytes_t f, input bit tuser);
        logic [47:0] dest;
        if (tuser || f.size() < MIN_LEN || f.size() > MAX_LEN) return 1'b0;
        dest = {f[0], f[1], f[2], f[3], f[4], f[5]};
        if (dest == MAC) return 1'b1;
`ifdef RX_FILTER_BROADCAST_EN
        if (dest == 48'hffffffffffff) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic drive_raw(input bytes_t f, input int lo, input int hi, input bit tuser);
        for (int i = lo; i <= hi; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = f[i];
            s_tlast  = (i == f.size() - 1);
            s_tuser  = tuser && (i == f.size() - 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drive_frame(input bytes_t f, input bit tuser);
        bit ok;
        ok = frame_ok(f, tuser);
        if (ok && cap_track) begin
            if (held + f.size() > DEPTH) ok = 1'b0;
            else held += f.size();
        end
        if (ok) begin
            for (int i = 0; i < f.size(); i++) exp_q.push_back({1'(i == f.size() - 1), f[i]});
            exp_frames++;
        end else begin
            if (exp_drops < 65535) exp_drops++;
            exp_pulses++;
        end
        drive_raw(f, 0, f.size() - 1, tuser);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_counts(input string tag);
        @(negedge clk);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames & 16'hffff));
        chk({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drops));
        chk({tag, "_drop_pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
        step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("idle_tvalid", 32'(m_tvalid), 32'd0);
        step();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: every output transfer must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (drop_pulse) pulse_cnt++;
                if (m_tvalid && m_tready) begin
                    chk("out_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0)
                        chk("out_byte", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t f, g, sync_beat;
        int     kind;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        step();

        // A lone tlast beat lets the filter leave its post-reset sync state.
        sync_beat = '{8'h00};
        drive_raw(sync_beat, 0, 0, 1'b0);
        idle();
        repeat (2) step();
        chk_counts("sync");

        // Good 38-byte frame: byte 0 shows up two edges after the tlast edge.
        f = make_frame(MAC, 38);
        drive_frame(f, 1'b0);
        idle();
        @(negedge clk);
        chk("lat_n0_tvalid", 32'(m_tvalid), 32'd0);
        chk("commit_frame_count", 32'(frame_count), 32'd1);
        @(negedge clk);
        chk("lat_n1_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk("lat_n2_tvalid", 32'(m_tvalid), 32'd1);
        chk("lat_n2_tdata", 32'(m_tdata), 32'(f[0]));
        step();
        wait_drain();

        // Foreign destination: dropped, one-cycle strobe right after the tlast edge.
        f = make_frame(48'h985aebdb066f, 38);
        drive_frame(f, 1'b0);
        idle();
        @(negedge clk);
        chk("drop_pulse_hi", 32'(drop_pulse), 32'd1);
        chk("drop_count_1", 32'(drop_count), 32'd1);
        @(negedge clk);
        chk("drop_pulse_lo", 32'(drop_pulse), 32'd0);
        step();
        wait_drain();
        chk_counts("badmac");

        // Errored frame then a good 26-byte frame back to back.
        drive_frame(make_frame(MAC, 38), 1'b1);
        drive_frame(make_frame(MAC, 26), 1'b0);
        idle();
        wait_drain();
        chk_counts("tuser");

        // Length limits.
        drive_frame(make_frame(MAC, 300), 1'b0);
        drive_frame(make_frame(MAC, 10), 1'b0);
        drive_frame(make_frame(MAC, 13), 1'b0);
        drive_frame(make_frame(MAC, 14), 1'b0);
        drive_frame(make_frame(MAC, 256), 1'b0);
        drive_frame(make_frame(MAC, 257), 1'b0);
        idle();
        wait_drain();
        chk_counts("length");

        // Stalled output while 20 back-to-back frames arrive.
        rdy_mode = 0;
        repeat (3) step();
        cap_track = 1'b1;
        held = 0;
        for (int i = 0; i < 20; i++) drive_frame(make_frame(MAC, 38), 1'b0);
        idle();
        cap_track = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("stall_tvalid", 32'(m_tvalid), 32'd1);
        chk("stall_tdata_hold", 32'(m_tdata), 32'(exp_q[0][7:0]));
        step();
        chk_counts("overflow");
        rdy_mode = 1;
        wait_drain();

        // Random frames with random output backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: drive_frame(make_frame(MAC, $urandom_range(14, 80)), 1'b0);
                1: drive_frame(make_frame({16'($urandom), 32'($urandom)}, $urandom_range(14, 60)), 1'b0);
                2: drive_frame(make_frame(MAC, $urandom_range(14, 60)), 1'b1);
                3: drive_frame(make_frame(MAC, $urandom_range(1, 13)), 1'b0);
                default: drive_frame(make_frame(MAC, $urandom_range(257, 290)), 1'b0);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                idle();
                wait_drain();
            end
        end
        idle();
        wait_drain();
        rdy_mode = 1;
        repeat (2) step();
        chk_counts("random");

        // Reset in the middle of a frame; its remainder must be discarded.
        f = make_frame(MAC, 38);
        drive_raw(f, 0, 19, 1'b0);
        rst = 1'b1;
        exp_frames = 0;
        exp_drops  = 0;
        repeat (2) step();
        @(negedge clk);
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        chk("midrst_drop_count", 32'(drop_count), 32'd0);
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        step();
        rst = 1'b0;
        drive_raw(f, 20, 37, 1'b0);
        g = make_frame(MAC, 30);
        drive_frame(g, 1'b0);
        idle();
        wait_drain();
        chk_counts("after_rst");

        // Broadcast destination.
        drive_frame(make_frame(48'hffffffffffff, 24), 1'b0);
        idle();
        wait_drain();
        chk_counts("bcast");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rx_frame_filter.md
# rx_frame_filter

Store-and-forward Ethernet receive filter between the tri-mode MAC receive AXI-Stream and `cmd_decoder_top` `rx_axis_*`, all in the `gtx_tclk_i` domain. Buffers each incoming byte-stream frame and checks destination MAC, frame length and the MAC error flag. Forwards only clean, complete frames addressed to the FPGA. Dropped frames never reach the decoder.

## Interface
- `FPGA_MAC_ADDR`, default 48'h5a0102030405: accepted destination MAC.
- `ADDR_WIDTH`, default 9: buffer depth is 2^ADDR_WIDTH bytes (512).
- `MIN_FRAME_BYTES`, default 14: shortest accepted frame (header only).
- `MAX_FRAME_BYTES`, default 256: longest accepted frame; must not exceed 2^ADDR_WIDTH.
- `gtx_tclk_i`, in, 1: clock, 125 MHz.
- `gtx_tresetn_i`, in, 1: reset gtx_tresetn_i, asynchronous, active-high; clock gtx_tclk_i.
- `s_axis_tdata`, in, 8: MAC receive byte.
- `s_axis_tvalid`, in, 1: byte valid. The MAC has no backpressure.
- `s_axis_tlast`, in, 1: last byte of frame.
- `s_axis_tuser`, in, 1: bad frame (FCS or PHY error); sampled with `tlast`.
- `m_axis_tdata`, out, 8: byte to the decoder.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tlast`, out, 1: last byte of the forwarded frame.
- `m_axis_tready`, in, 1: decoder ready.
- `frame_count`, out, 16: frames committed; wraps.
- `drop_count`, out, 16: frames dropped; saturates at 16'hffff.
- `drop_pulse`, out, 1: one-cycle strobe on each drop.

## Operation
- Storage: RAM of 9-bit words `{last, data}`. Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits.
  - Occupancy is `wr_ptr - rd_ptr`.
  - Full when occupancy = 2^ADDR_WIDTH.
- Write FSM states: SYNC, HDR, BODY, DROP.
  - SYNC (entered from reset): discard bytes until a `tvalid&tlast` beat, then go to HDR. A partial frame in flight at reset release is never forwarded.
  - HDR, bytes 0-5: write each byte and compare against `FPGA_MAC_ADDR`, most significant byte first. On a mismatch, go to DROP. After byte 5 matches, go to BODY.
  - BODY: write bytes and count the length. If length exceeds `MAX_FRAME_BYTES`, or the buffer is full when a byte arrives, go to DROP. That byte is not written.
  - On `tvalid&tlast`, whether in HDR or BODY, the frame commits if all of these hold:
    - `tuser`=0;
    - the MAC matched;
    - `MIN_FRAME_BYTES` <= length <= `MAX_FRAME_BYTES`.
  - Commit: the last byte is written with `last`=1, `commit_ptr <= wr_ptr+1`, `frame_count` increments, and the FSM returns to HDR.
  - Otherwise the frame is dropped: `wr_ptr <= commit_ptr`, `drop_count` increments, `drop_pulse`=1, and the FSM returns to HDR.
  - DROP: ignore bytes until `tvalid&tlast`, then perform the drop actions above. A drop is counted exactly once per frame.
- Read side: the output is valid only for committed data (`rd_ptr != commit_ptr`).
  - Read path is RAM read register plus a one-word skid output register.
  - Standard AXI-S: `tvalid` is held until `tready`, and `tdata`/`tlast` are stable while stalled.
  - A transfer occurs on `tvalid&tready`.
  - Sustains one byte per cycle with `tready` held high.
- Simultaneous commit and read: the read side sees the new `commit_ptr` on the next cycle. The full check uses the registered `rd_ptr` (conservative).
- Reset: all pointers = 0, FSM = SYNC, counters cleared, buffered frames discarded.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `frame_count`=0, `drop_count`=0, `drop_pulse`=0.
- Latency: with an empty buffer and `tready`=1, byte 0 appears on `m_axis` in cycle N+2, where cycle N is the edge accepting the input `tlast`.
- Per-frame latency is therefore frame length + 2 cycles.
- `drop_pulse` asserts the cycle after the `tlast` edge.
- `frame_count` and `drop_count` update on that same edge.
- Back-to-back input frames with zero idle cycles are supported.

## Configuration
- `RX_FILTER_BROADCAST_EN`:
  - Defined: destination 48'hffffffffffff is also accepted in HDR.
  - Undefined: only `FPGA_MAC_ADDR` is accepted, and broadcast frames are dropped.

## Test plan
- 38-byte write frame to 5a0102030405, `tuser`=0, `tready`=1 -> identical 38 bytes out, `tlast` on byte 38, first byte 2 cycles after input `tlast`, `frame_count`=1.
- Frame to 985aebdb066f -> no output, `drop_count`=1, one `drop_pulse`.
- Good frame with `tuser`=1 on `tlast` -> dropped; a following good 26-byte frame is forwarded intact with `wr_ptr` rewound correctly.
- 300-byte frame, and separately a 10-byte frame -> both dropped, `drop_count`=2.
- `tready`=0 while 20 back-to-back 38-byte frames arrive -> frames 1-13 committed (494 bytes); frames overflowing 512 are dropped. Release `tready` -> 13 intact frames out, in order.
- Assert reset mid-frame at byte 20, release mid-frame -> that frame's remainder is ignored (SYNC), the next frame is forwarded; broadcast frame accepted only with `RX_FILTER_BROADCAST_EN`.
